// File: rtl/ro_enc_debounce_pkg.sv
// Shared constants and types for the rotary-encoder / push-switch input conditioner.
// Front-panel clock, default debounce length and the A/B settle FSM encoding live here.
package ro_enc_debounce_pkg;

   localparam int unsigned MPS_CLK_HZ           = 100_000_000;
   localparam int unsigned MPS_DEBOUNCE_DEFAULT = 50_000;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } enc_state_e;

   // Per-channel status handed from a filter channel to the top.
   typedef struct packed {
      logic s;        // last synchroniser stage
      logic f;        // debounced level
      logic acc;      // filter accepts s into f on this cycle
      logic settled;  // s has held its value for DEBOUNCE_CYCLES cycles
   } ch_stat_t;

endpackage

// File: rtl/ro_enc_debounce_ch.sv
// One conditioned input: synchroniser chain, no-partial-credit debounce filter,
// accept strobe and a start-up stability detector.
module ro_enc_debounce_ch
   import ro_enc_debounce_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = MPS_DEBOUNCE_DEFAULT,
   parameter int unsigned CNT_W           = 16
) (
   input  logic     i_clk,
   input  logic     i_rst,
   input  logic     i_raw,
   input  logic     i_load,
   output ch_stat_t o_stat
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   f_q, f_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0]       stab_q, stab_d;
   logic                   s, s_nxt, acc, settled;

   assign s       = sync_q[SYNC_STAGES-1];
   assign s_nxt   = sync_q[SYNC_STAGES-2];
   assign acc     = (s != f_q) && (cnt_q == CNT_LAST);
   assign settled = (s_nxt == s) && (stab_q == CNT_LAST);

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], i_raw};
      f_d    = f_q;
      cnt_d  = cnt_q;
      if (i_load) begin
         f_d   = s;
         cnt_d = '0;
      end else if (s == f_q) begin
         cnt_d = '0;
      end else if (acc) begin
         f_d   = s;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Stability looks one stage ahead so it completes on the same cycle a filter would accept.
   always_comb begin
      stab_d = stab_q;
      if (s_nxt != s) begin
         stab_d = '0;
      end else if (stab_q != CNT_LAST) begin
         stab_d = stab_q + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         sync_q <= '0;
         f_q    <= 1'b0;
         cnt_q  <= '0;
         stab_q <= '0;
      end else begin
         sync_q <= sync_d;
         f_q    <= f_d;
         cnt_q  <= cnt_d;
         stab_q <= stab_d;
      end
   end

   assign o_stat = '{s: s, f: f_q, acc: acc, settled: settled};

endmodule

// File: rtl/ro_enc_debounce.sv
// Front-panel conditioner ahead of the rotary decoder: three debounce channels,
// the A/B settle FSM, the illegal double-change detector and the push rising-edge pulse.
module ro_enc_debounce
   import ro_enc_debounce_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = MPS_DEBOUNCE_DEFAULT,
   parameter int unsigned CNT_W           = 16
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_ro_enc_raw_a,
   input  logic i_ro_enc_raw_b,
   input  logic i_sw_push_raw,
   output logic o_ro_enc_state_a,
   output logic o_ro_enc_state_b,
   output logic o_ro_enc_valid,
   output logic o_sw_push,
   output logic o_sw_push_rise,
   output logic o_ab_illegal
);

   ch_stat_t   st_a, st_b, st_p;
   enc_state_e state_q, state_d;
   logic       load_ab;
   logic       out_a_q, out_a_d;
   logic       out_b_q, out_b_d;
   logic       valid_q, valid_d;
   logic       ill_q, ill_d;
   logic       push_prev_q;
   logic       rise_q, rise_d;
   logic       unused_push;

   ro_enc_debounce_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
   ) u_ch_a (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_raw (i_ro_enc_raw_a),
      .i_load(load_ab),
      .o_stat(st_a)
   );

   ro_enc_debounce_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
   ) u_ch_b (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_raw (i_ro_enc_raw_b),
      .i_load(load_ab),
      .o_stat(st_b)
   );

   ro_enc_debounce_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
   ) u_ch_push (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_raw (i_sw_push_raw),
      .i_load(1'b0),
      .o_stat(st_p)
   );

   // The push path only needs the debounced level.
   assign unused_push = ^{st_p.s, st_p.acc, st_p.settled};

   // A/B outputs load on the same edge the filters update, so they add no extra latency.
   always_comb begin
      state_d = state_q;
      load_ab = 1'b0;
      out_a_d = out_a_q;
      out_b_d = out_b_q;
      valid_d = valid_q;
      ill_d   = 1'b0;
      case (state_q)
         ST_INIT: begin
            if (st_a.settled && st_b.settled) begin
               load_ab = 1'b1;
               out_a_d = st_a.s;
               out_b_d = st_b.s;
               valid_d = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (st_a.acc) out_a_d = st_a.s;
            if (st_b.acc) out_b_d = st_b.s;
            ill_d = st_a.acc && st_b.acc;
         end
         default: state_d = ST_INIT;
      endcase
   end

   assign rise_d = st_p.f & ~push_prev_q;

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_q     <= ST_INIT;
         out_a_q     <= 1'b0;
         out_b_q     <= 1'b0;
         valid_q     <= 1'b0;
         ill_q       <= 1'b0;
         push_prev_q <= 1'b0;
         rise_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_a_q     <= out_a_d;
         out_b_q     <= out_b_d;
         valid_q     <= valid_d;
         ill_q       <= ill_d;
         push_prev_q <= st_p.f;
         rise_q      <= rise_d;
      end
   end

   assign o_ro_enc_state_a = out_a_q;
   assign o_ro_enc_state_b = out_b_q;
   assign o_ro_enc_valid   = valid_q;
   assign o_ab_illegal     = ill_q;
   assign o_sw_push        = st_p.f;
   assign o_sw_push_rise   = rise_q;

endmodule

// File: tb/tb_ro_enc_debounce.sv
// Directed bench for ro_enc_debounce with DEBOUNCE_CYCLES=8, SYNC_STAGES=2:
// a clean raw edge reaches the debounced outputs 10 clock edges later.
module tb_ro_enc_debounce;

   logic clk = 1'b0;
   logic rst_n;
   logic raw_a, raw_b, raw_p;
   logic st_a, st_b, vld, push, push_rise, ab_ill;

   int n_cmp = 0;
   int n_err = 0;
   int ill_cnt = 0;
   int rise_cnt = 0;
   int chg = 0;

   always #5 clk = ~clk;

   ro_enc_debounce #(
      .SYNC_STAGES    (2),
      .DEBOUNCE_CYCLES(8),
      .CNT_W          (4)
   ) dut (
      .i_clk           (clk),
      .i_rst           (rst_n),
      .i_ro_enc_raw_a  (raw_a),
      .i_ro_enc_raw_b  (raw_b),
      .i_sw_push_raw   (raw_p),
      .o_ro_enc_state_a(st_a),
      .o_ro_enc_state_b(st_b),
      .o_ro_enc_valid  (vld),
      .o_sw_push       (push),
      .o_sw_push_rise  (push_rise),
      .o_ab_illegal    (ab_ill)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock edge; outputs are sampled 1 time unit after it and pulses are tallied.
   task automatic tick();
      @(posedge clk);
      #1;
      if (ab_ill)    ill_cnt++;
      if (push_rise) rise_cnt++;
   endtask

   initial begin
      rst_n = 1'b0;
      raw_a = 1'b1;
      raw_b = 1'b1;
      raw_p = 1'b0;
      repeat (3) tick();
      chk("rst_valid", int'(vld), 0);
      chk("rst_a", int'(st_a), 0);
      chk("rst_b", int'(st_b), 0);
      chk("rst_push", int'(push), 0);
      chk("rst_rise", int'(push_rise), 0);
      chk("rst_ill", int'(ab_ill), 0);

      // start-up settle with A=B=1
      rst_n = 1'b1;
      ill_cnt = 0;
      repeat (9) tick();
      chk("init_valid_c9", int'(vld), 0);
      chk("init_a_c9", int'(st_a), 0);
      chk("init_b_c9", int'(st_b), 0);
      tick();
      chk("init_valid_c10", int'(vld), 1);
      chk("init_a_c10", int'(st_a), 1);
      chk("init_b_c10", int'(st_b), 1);
      repeat (10) tick();
      chk("init_no_ill", ill_cnt, 0);
      chk("init_valid_hold", int'(vld), 1);

      // clean A fall
      raw_a = 1'b0;
      repeat (9) tick();
      chk("a_fall_c9", int'(st_a), 1);
      tick();
      chk("a_fall_c10", int'(st_a), 0);
      chk("a_fall_b_hold", int'(st_b), 1);

      // B bouncing every 3 cycles, then held 0
      chg = 0;
      for (int i = 0; i < 10; i++) begin
         raw_b = ~raw_b;
         repeat (3) begin
            tick();
            if (st_b != 1'b1) chg++;
         end
      end
      chk("b_bounce_stable", chg, 0);
      raw_b = 1'b0;
      repeat (9) tick();
      chk("b_fall_c9", int'(st_b), 1);
      tick();
      chk("b_fall_c10", int'(st_b), 0);

      // simultaneous A/B change
      ill_cnt = 0;
      raw_a = 1'b1;
      raw_b = 1'b1;
      repeat (9) tick();
      chk("ab_c9_a", int'(st_a), 0);
      chk("ab_c9_b", int'(st_b), 0);
      chk("ab_c9_ill", ill_cnt, 0);
      tick();
      chk("ab_c10_a", int'(st_a), 1);
      chk("ab_c10_b", int'(st_b), 1);
      chk("ab_c10_ill", int'(ab_ill), 1);
      tick();
      chk("ab_c11_ill", int'(ab_ill), 0);
      chk("ab_ill_count", ill_cnt, 1);

      // push with bounce, hold, release
      rise_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         raw_p = ((i % 2) == 0);
         if (i < 4) tick();
      end
      repeat (9) tick();
      chk("push_c9", int'(push), 0);
      tick();
      chk("push_c10", int'(push), 1);
      chk("push_c10_rise", int'(push_rise), 0);
      tick();
      chk("push_c11_rise", int'(push_rise), 1);
      tick();
      chk("push_c12_rise", int'(push_rise), 0);
      repeat (8) tick();
      raw_p = 1'b0;
      repeat (12) tick();
      chk("push_released", int'(push), 0);
      chk("push_rise_count", rise_cnt, 1);

      // reset in the middle of a pending A change
      raw_a = 1'b0;
      repeat (7) tick();
      rst_n = 1'b0;
      tick();
      chk("mid_rst_valid", int'(vld), 0);
      chk("mid_rst_a", int'(st_a), 0);
      chk("mid_rst_b", int'(st_b), 0);
      chk("mid_rst_push", int'(push), 0);
      rst_n = 1'b1;
      ill_cnt = 0;
      repeat (9) tick();
      chk("resettle_valid_c9", int'(vld), 0);
      chk("resettle_b_c9", int'(st_b), 0);
      tick();
      chk("resettle_valid_c10", int'(vld), 1);
      chk("resettle_a_c10", int'(st_a), 0);
      chk("resettle_b_c10", int'(st_b), 1);
      chk("resettle_no_ill", ill_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
